// File: rtl/serial_subtractor.sv
// Multi-cycle ripple-borrow subtractor: diff = in0 - in1 - bin, resolved SLICE bits per clock,
// least-significant slice first, with a start/done handshake and held result flags.
module serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             zero,
  output logic             ovf,
  output logic [1:0]       dbg_state
);

  localparam int N     = WIDTH / SLICE;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   part_q, part_d;
  logic               brw_q, brw_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               msb0_q, msb0_d;
  logic               msb1_q, msb1_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               borrow_q, borrow_d;
  logic               zero_q, zero_d;
  logic               ovf_q, ovf_d;

  logic [SLICE:0]       slice_sum;
  logic [WIDTH+SLICE-1:0] part_cat;
  logic [WIDTH-1:0]     part_next;

  // Subtraction as addition of the complement; carry-out of 1 means no borrow.
  always_comb begin
    slice_sum = {1'b0, a_q[SLICE-1:0]} + {1'b0, ~b_q[SLICE-1:0]} + {{SLICE{1'b0}}, ~brw_q};
    part_cat  = {slice_sum[SLICE-1:0], part_q};
    part_next = part_cat[WIDTH+SLICE-1:SLICE];
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    part_d   = part_q;
    brw_d    = brw_q;
    idx_d    = idx_q;
    msb0_d   = msb0_q;
    msb1_d   = msb1_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          a_d     = in0;
          b_d     = in1;
          brw_d   = bin;
          part_d  = '0;
          idx_d   = '0;
          msb0_d  = in0[WIDTH-1];
          msb1_d  = in1[WIDTH-1];
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        a_d    = a_q >> SLICE;
        b_d    = b_q >> SLICE;
        brw_d  = ~slice_sum[SLICE];
        part_d = part_next;
        idx_d  = idx_q + IDX_W'(1);
        // Visible outputs only move here, so partial results never leak out.
        if (idx_q == LAST_IDX) begin
          state_d  = S_DONE;
          diff_d   = part_next;
          borrow_d = ~slice_sum[SLICE];
          zero_d   = (part_next == '0);
          ovf_d    = (msb0_q != msb1_q) && (part_next[WIDTH-1] != msb0_q);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      part_q   <= '0;
      brw_q    <= 1'b0;
      idx_q    <= '0;
      msb0_q   <= 1'b0;
      msb1_q   <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      part_q   <= part_d;
      brw_q    <= brw_d;
      idx_q    <= idx_d;
      msb0_q   <= msb0_d;
      msb1_q   <= msb1_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign diff      = diff_q;
  assign borrow    = borrow_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: directed vector table and handshake corner cases on an
// 8-bit/4-bit-slice instance, random operands against an arithmetic model on a 16-bit instance.
module tb_serial_subtractor;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start8 = 1'b0, bin8 = 1'b0;
  logic [7:0]  in0_8 = '0, in1_8 = '0;
  logic        busy8, done8, borrow8, zero8, ovf8;
  logic [7:0]  diff8;
  logic [1:0]  dbg8;

  logic        start16 = 1'b0, bin16 = 1'b0;
  logic [15:0] in0_16 = '0, in1_16 = '0;
  logic        busy16, done16, borrow16, zero16, ovf16;
  logic [15:0] diff16;
  logic [1:0]  dbg16;

  serial_subtractor #(.WIDTH(8), .SLICE(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .in0(in0_8), .in1(in1_8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8), .zero(zero8), .ovf(ovf8),
    .dbg_state(dbg8)
  );

  serial_subtractor #(.WIDTH(16), .SLICE(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .in0(in0_16), .in1(in1_16), .bin(bin16),
    .busy(busy16), .done(done16), .diff(diff16), .borrow(borrow16), .zero(zero16), .ovf(ovf16),
    .dbg_state(dbg16)
  );

  // ---------------- scoreboard ----------------
  int tests = 0;
  int fails = 0;
  logic [15:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Starts one op from idle, optionally scrambles operands mid-flight, waits for done.
  task automatic run_op(input bit w16, input logic [15:0] a, input logic [15:0] b, input bit bi,
                        input bit scramble, output logic [15:0] d, output logic br,
                        output logic z, output logic o, output int lat);
    logic [15:0] held;
    bit got;
    bit moved;
    if (w16) begin in0_16 = a; in1_16 = b; bin16 = bi; start16 = 1'b1; end
    else     begin in0_8 = a[7:0]; in1_8 = b[7:0]; bin8 = bi; start8 = 1'b1; end
    @(posedge clk); #1;
    start8 = 1'b0; start16 = 1'b0;
    if (scramble) begin
      in0_16 = 16'($urandom); in1_16 = 16'($urandom); bin16 = 1'($urandom);
      in0_8 = 8'($urandom); in1_8 = 8'($urandom); bin8 = 1'($urandom);
    end
    held = w16 ? diff16 : {8'h00, diff8};
    got = 1'b0; moved = 1'b0; lat = 0;
    while (!got && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (w16 ? done16 : done8) got = 1'b1;
      else if ((w16 ? diff16 : {8'h00, diff8}) != held) moved = 1'b1;
    end
    if (!got) begin
      fails++; tests++;
      $display("FAIL done_timeout: got no done expected done within 20 cycles");
    end
    if (moved) begin
      fails++; tests++;
      $display("FAIL diff_hold: got diff change while busy expected stable");
    end
    d  = w16 ? diff16 : {8'h00, diff8};
    br = w16 ? borrow16 : borrow8;
    z  = w16 ? zero16 : zero8;
    o  = w16 ? ovf16 : ovf8;
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bi;
    logic [7:0] e_diff;
    logic       e_borrow;
    logic       e_zero;
    logic       e_ovf;
  } vec_t;

  vec_t vecs[6];

  // ---------------- test sequence ----------------
  initial begin
    logic [15:0] d, d2;
    logic br, z, o;
    int lat, done_cnt;
    int sa, sb, sd;
    logic [16:0] wide;

    vecs[0] = '{8'h50, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'h3C, 8'h3B, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", {31'd0, busy8}, 0);
    chk("reset_done", {31'd0, done8}, 0);
    chk("reset_diff", {24'd0, diff8}, 0);
    chk("reset_flags", {29'd0, borrow8, zero8, ovf8}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vector table.
    for (int i = 0; i < 6; i++) begin
      run_op(1'b0, {8'h00, vecs[i].a}, {8'h00, vecs[i].b}, vecs[i].bi, 1'b1, d, br, z, o, lat);
      chk($sformatf("vec%0d_latency", i), lat, 2);
      chk($sformatf("vec%0d_diff", i), d, {8'h00, vecs[i].e_diff});
      chk($sformatf("vec%0d_borrow", i), {31'd0, br}, {31'd0, vecs[i].e_borrow});
      chk($sformatf("vec%0d_zero", i), {31'd0, z}, {31'd0, vecs[i].e_zero});
      chk($sformatf("vec%0d_ovf", i), {31'd0, o}, {31'd0, vecs[i].e_ovf});
      @(posedge clk); #1;
      chk($sformatf("vec%0d_done_one_cycle", i), {31'd0, done8}, 0);
      chk($sformatf("vec%0d_result_held", i), {24'd0, diff8}, {24'd0, vecs[i].e_diff});
    end

    // Async reset mid-operation (previous result 7F/ovf is still showing).
    in0_8 = 8'h12; in1_8 = 8'h34; bin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1; start8 = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midreset_busy", {31'd0, busy8}, 0);
    chk("midreset_done", {31'd0, done8}, 0);
    chk("midreset_diff", {24'd0, diff8}, 0);
    chk("midreset_flags", {29'd0, borrow8, zero8, ovf8}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    done_cnt = 0;
    repeat (5) begin @(posedge clk); #1; if (done8) done_cnt++; end
    chk("midreset_no_done", done_cnt, 0);
    run_op(1'b0, 16'h0005, 16'h0003, 1'b0, 1'b0, d, br, z, o, lat);
    chk("post_reset_diff", d, 16'h0002);
    chk("post_reset_latency", lat, 2);
    @(posedge clk); #1;

    // Start held high while busy: exactly one done.
    in0_8 = 8'h09; in1_8 = 8'h04; bin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    in0_8 = 8'hAA; in1_8 = 8'h11;
    @(posedge clk); #1;
    start8 = 1'b0;
    done_cnt = 0;
    if (done8) done_cnt++;
    repeat (6) begin @(posedge clk); #1; if (done8) done_cnt++; end
    chk("busy_start_done_count", done_cnt, 1);
    chk("busy_start_diff", {24'd0, diff8}, 32'h05);

    // Back-to-back: start in the done cycle.
    run_op(1'b0, 16'h0040, 16'h0001, 1'b0, 1'b0, d, br, z, o, lat);
    chk("b2b_first_diff", d, 16'h003F);
    in0_8 = 8'h10; in1_8 = 8'h20; bin8 = 1'b1; start8 = 1'b1;
    @(posedge clk); #1; start8 = 1'b0;
    chk("b2b_busy", {31'd0, busy8}, 1);
    chk("b2b_hold_between", {24'd0, diff8}, 32'h3F);
    @(posedge clk); #1;
    chk("b2b_hold_between2", {24'd0, diff8}, 32'h3F);
    chk("b2b_not_done_early", {31'd0, done8}, 0);
    @(posedge clk); #1;
    chk("b2b_second_done", {31'd0, done8}, 1);
    chk("b2b_second_diff", {24'd0, diff8}, 32'hEF);
    chk("b2b_second_borrow", {31'd0, borrow8}, 1);
    @(posedge clk); #1;

    // Random ops on the 16-bit instance against an arithmetic model.
    for (int i = 0; i < 1000; i++) begin
      logic [15:0] a, b;
      logic bi;
      a  = 16'($urandom);
      b  = 16'($urandom);
      bi = 1'($urandom);
      if ($urandom_range(0, 9) == 0) b = a;
      run_op(1'b1, a, b, bi, 1'b1, d, br, z, o, lat);
      exp_q.push_back(16'(int'(a) - int'(b) - int'(bi)));
      d2 = exp_q.pop_front();
      chk("rand_diff", d, d2);
      chk("rand_latency", lat, 4);
      wide = {1'b0, b} + {16'd0, bi};
      chk("rand_borrow", {31'd0, br}, {31'd0, ({1'b0, a} < wide)});
      chk("rand_zero", {31'd0, z}, {31'd0, (d2 == 16'd0)});
      sa = int'($signed(a));
      sb = int'($signed(b));
      sd = sa - sb - int'(bi);
      chk("rand_ovf", {31'd0, o}, {31'd0, (sd > 32767 || sd < -32768)});
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got time limit expected completion");
    $fatal(1, "timeout");
  end

endmodule
